// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing controller for the 5-stage core.
// It resolves load-use hazards, taken-branch flushes and multi-cycle data
// memory accesses. It also detects memory timeouts and keeps saturating
// stall and flush statistics.
module hazard_stall_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              IDEX_MemRead_i,
   input  logic [REG_AW-1:0] IDEX_RtAddr_i,
   input  logic [REG_AW-1:0] IFID_RsAddr_i,
   input  logic [REG_AW-1:0] IFID_RtAddr_i,
   input  logic              branch_taken_i,
   input  logic              dmem_req_i,
   input  logic              dmem_ack_i,
   output logic              PC_write_o,
   output logic              IFID_write_o,
   output logic              IFID_flush_o,
   output logic              IDEX_bubble_o,
   output logic              pipe_stall_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] WLAST = WCW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_ERROR    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic rr_pc, rr_ifid, rr_flush, rr_bubble;

   // Load-use detect; $0 is hardwired, so a load to it never creates a hazard.
   assign load_use = IDEX_MemRead_i && (IDEX_RtAddr_i != '0) &&
                     ((IDEX_RtAddr_i == IFID_RsAddr_i) ||
                      (IDEX_RtAddr_i == IFID_RtAddr_i));

   // Normal-flow controls: a load-use bubble beats the branch flush, and the branch re-resolves next cycle.
   always_comb begin
      rr_pc     = 1'b1;
      rr_ifid   = 1'b1;
      rr_flush  = 1'b0;
      rr_bubble = 1'b0;
      if (load_use) begin
         rr_pc     = 1'b0;
         rr_ifid   = 1'b0;
         rr_bubble = 1'b1;
      end else if (branch_taken_i) begin
         rr_flush  = 1'b1;
      end
   end

   // Next state, wait counter and Mealy control outputs.
   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IFID_flush_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
      pipe_stall_o  = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_RUN;
         end
         S_RUN: begin
            if (dmem_req_i && !dmem_ack_i) begin
               IDEX_bubble_o = 1'b0;
               state_d       = S_MEM_WAIT;
               wcnt_d        = WCW'(1);
            end else begin
               PC_write_o    = rr_pc;
               IFID_write_o  = rr_ifid;
               IFID_flush_o  = rr_flush;
               IDEX_bubble_o = rr_bubble;
               pipe_stall_o  = 1'b0;
            end
         end
         S_MEM_WAIT: begin
            if (!dmem_ack_i) begin
               IDEX_bubble_o = 1'b0;
               if (wcnt_q == WLAST) begin
                  state_d = S_ERROR;
                  wcnt_d  = '0;
               end else begin
                  wcnt_d  = wcnt_q + WCW'(1);
               end
            end else begin
               // The ack releases the freeze in the same cycle, because MEM/WB captures on this edge.
               PC_write_o    = rr_pc;
               IFID_write_o  = rr_ifid;
               IFID_flush_o  = rr_flush;
               IDEX_bubble_o = rr_bubble;
               pipe_stall_o  = 1'b0;
               state_d       = S_RUN;
               wcnt_d        = '0;
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Saturating statistics: stalls count only while the pipe is live.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((state_q == S_RUN || state_q == S_MEM_WAIT) && !PC_write_o &&
          (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (IFID_flush_o && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State and counter registers; reset aborts any wait at once.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         wcnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign err_o       = (state_q == S_ERROR);
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios and random traffic, checked
// against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

   localparam int TMO  = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, mr = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
   logic [4:0] ida = '0, rs = '0, rt = '0;
   logic pc_o, ifid_o, flush_o, bub_o, stall_o, err_o;
   logic [CW-1:0] scnt_o, fcnt_o;

   int total = 0;
   int bad   = 0;

   // model state
   bit m_on, m_err;
   int m_wait, m_scnt, m_fcnt;
   bit e_pc, e_ifid, e_flush, e_bub, e_stall, e_frz;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_AW(5), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .IDEX_MemRead_i(mr), .IDEX_RtAddr_i(ida),
      .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
      .branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
      .PC_write_o(pc_o), .IFID_write_o(ifid_o), .IFID_flush_o(flush_o),
      .IDEX_bubble_o(bub_o), .pipe_stall_o(stall_o), .err_o(err_o),
      .stall_cnt_o(scnt_o), .flush_cnt_o(fcnt_o)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_on = 0; m_err = 0; m_wait = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   // Expected controls this cycle, derived from the rules as written.
   task automatic m_comb();
      bit hz;
      {e_pc, e_ifid, e_flush, e_bub, e_stall, e_frz} = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      if (m_on && !m_err) begin
         e_frz = (m_wait == 0) ? (req && !ack) : !ack;
         hz = mr && (ida != 0) && (ida == rs || ida == rt);
         if (e_frz) begin
            e_bub = 0;
         end else begin
            e_stall = 0;
            e_bub   = hz;
            e_pc    = !hz;
            e_ifid  = !hz;
            e_flush = !hz && br;
         end
      end
   endtask

   task automatic m_edge();
      if (m_on && !m_err) begin
         if (!e_pc && m_scnt < CMAX) m_scnt++;
         if (e_flush && m_fcnt < CMAX) m_fcnt++;
         if (e_frz) begin
            m_wait++;
            if (m_wait == TMO) begin m_err = 1; m_wait = 0; end
         end else m_wait = 0;
      end else if (!m_on) m_on = start;
   endtask

   task automatic chk_regs();
      chk("stall_cnt", int'(scnt_o), m_scnt);
      chk("flush_cnt", int'(fcnt_o), m_fcnt);
      chk("err", int'(err_o), int'(m_err));
   endtask

   // One clock: drive, check combinational controls, clock, check registers.
   task automatic cyc(input bit st, input bit mr_, input int ida_, input int rs_,
                      input int rt_, input bit br_, input bit req_, input bit ack_);
      start = st; mr = mr_; ida = 5'(ida_); rs = 5'(rs_); rt = 5'(rt_);
      br = br_; req = req_; ack = ack_;
      #1;
      m_comb();
      chk("PC_write", int'(pc_o), int'(e_pc));
      chk("IFID_write", int'(ifid_o), int'(e_ifid));
      chk("IFID_flush", int'(flush_o), int'(e_flush));
      chk("IDEX_bubble", int'(bub_o), int'(e_bub));
      chk("pipe_stall", int'(stall_o), int'(e_stall));
      @(posedge clk);
      m_edge();
      #1;
      chk_regs();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      m_reset();
      repeat (n) begin
         @(posedge clk); #1;
         chk_regs();
      end
      rst = 1'b1;
   endtask

   task automatic reset_start();
      do_reset(1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      m_reset();
      @(posedge clk); #1;
      // reset, then idle outputs through the start cycle
      do_reset(3);
      chk("idle_pc", int'(pc_o), 0);
      chk("idle_stall", int'(stall_o), 1);
      chk("idle_bubble", int'(bub_o), 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("run_pc", int'(pc_o), 1);

      // load-use on rs, then a load to $0 (no hazard)
      cyc(0, 1, 5, 5, 7, 0, 0, 0);
      chk("lu_stall_cnt", int'(scnt_o), 1);
      cyc(0, 1, 0, 3, 0, 0, 0, 0);
      chk("r0_pc", int'(pc_o), 1);
      chk("r0_stall_cnt", int'(scnt_o), 1);

      // load-use coincident with a taken branch
      cyc(0, 1, 9, 1, 9, 1, 0, 0);
      chk("lu_br_flush", int'(flush_o), 0);
      cyc(0, 0, 0, 1, 9, 1, 0, 0);
      chk("br_flush_cnt", int'(fcnt_o), 1);

      // memory access acked on the fifth cycle; then a zero-wait access
      reset_start();
      repeat (4) cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      chk("mem_release", int'(stall_o), 0);
      chk("mem_stall_cnt", int'(scnt_o), 4);
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      chk("zero_wait_cnt", int'(scnt_o), 4);

      // timeout into ERROR, sticky, async reset clears it mid-cycle
      repeat (TMO) cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk("tmo_err", int'(err_o), 1);
      repeat (3) cyc(0, 0, 0, 0, 0, 1, 1, 1);
      chk("err_sticky", int'(err_o), 1);
      #2 rst = 1'b0;
      #1 chk("async_rst_err", int'(err_o), 0);
      m_reset();
      @(posedge clk); #1;
      rst = 1'b1;

      // flush counter saturation
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (20) cyc(0, 0, 0, 0, 0, 1, 0, 0);
      chk("flush_sat", int'(fcnt_o), CMAX);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (i % 75 == 0) reset_start();
         cyc(($urandom_range(0, 7) == 0), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
